// File: rtl/rs485_txn_ctrl_if.sv
// rtl/rs485_txn_ctrl_if.sv - host request/response and master485n byte-bus signal bundle
interface rs485_txn_ctrl_if;
  logic        p_in_req;
  logic [7:0]  p_in_req_adr;
  logic [7:0]  p_in_req_cmd;
  logic [2:0]  p_in_req_len;
  logic [31:0] p_in_req_data;
  logic        p_out_busy;
  logic        p_out_done;
  logic [2:0]  p_out_err;
  logic [2:0]  p_out_ack_len;
  logic [31:0] p_out_ack_data;
  logic        p_out_txd_rdy;
  logic [7:0]  p_out_txd;
  logic        p_in_txd_rd;
  logic [7:0]  p_in_rxd;
  logic        p_in_rxd_wr;
  logic [2:0]  p_in_status;

  // master: requester plus PHY engine side; slave: the transaction sequencer
  modport master (
    output p_in_req, p_in_req_adr, p_in_req_cmd, p_in_req_len, p_in_req_data,
    output p_in_txd_rd, p_in_rxd, p_in_rxd_wr, p_in_status,
    input  p_out_busy, p_out_done, p_out_err, p_out_ack_len, p_out_ack_data,
    input  p_out_txd_rdy, p_out_txd
  );
  modport slave (
    input  p_in_req, p_in_req_adr, p_in_req_cmd, p_in_req_len, p_in_req_data,
    input  p_in_txd_rd, p_in_rxd, p_in_rxd_wr, p_in_status,
    output p_out_busy, p_out_done, p_out_err, p_out_ack_len, p_out_ack_data,
    output p_out_txd_rdy, p_out_txd
  );
endinterface

// File: rtl/rs485_txn_ctrl.sv
// rtl/rs485_txn_ctrl.sv - RS-485 transaction sequencer: frame TX, response check, timeout
// Retry counter and S_GAP exist only when RS485_CTRL_RETRY_EN is defined.
module rs485_txn_ctrl #(
  parameter int G_TIMEOUT = 1000000,
  parameter int G_RETRY   = 2,
  parameter int G_GAP     = 256
) (
  input logic             p_in_clk,
  input logic             p_in_rst,
  rs485_txn_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_CHECK, S_GAP, S_DONE} state_t;

  if (G_TIMEOUT < 2 || G_TIMEOUT > 16777215 || G_RETRY < 0 || G_RETRY > 7 ||
      G_GAP < 1 || G_GAP > 65535) begin : g_cfg_check
    $error("rs485_txn_ctrl: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [7:0]  adr_q, adr_d, cmd_q, cmd_d, txd_q, txd_d;
  logic [2:0]  len_q, len_d, tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [2:0]  ack_len_q, ack_len_d, err_q, err_d, chk_err;
  logic [31:0] data_q, data_d, ack_data_q, ack_data_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic        mism_q, mism_d, ovf_q, ovf_d, tmo_q, tmo_d, rx_err_q, rx_err_d;
  logic        stat_prev_q, stat_edge, last_rd, tmo_hit;
`ifdef RS485_CTRL_RETRY_EN
  logic [2:0]  retry_q, retry_d;
  logic [15:0] gap_q, gap_d;
`endif

  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [7:0] adr,
                                         input logic [7:0] cmd, input logic [31:0] data);
    case (idx)
      3'd0:    tx_byte = adr;
      3'd1:    tx_byte = cmd;
      3'd2:    tx_byte = data[31:24];
      3'd3:    tx_byte = data[23:16];
      3'd4:    tx_byte = data[15:8];
      default: tx_byte = data[7:0];
    endcase
  endfunction

  assign stat_edge = (bus.p_in_status != 3'd0) && !stat_prev_q;
  assign last_rd   = bus.p_in_txd_rd && (tx_idx_q == len_q + 3'd1);
  assign tmo_hit   = (tmo_cnt_q == 24'(G_TIMEOUT - 1));

  always_comb begin
    if (tmo_q)                         chk_err = 3'd1;
    else if (rx_err_q)                 chk_err = 3'd2;
    else if (mism_q)                   chk_err = 3'd3;
    else if (ovf_q || rx_idx_q < 3'd2) chk_err = 3'd4;
    else                               chk_err = 3'd0;
  end

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.p_in_req) state_d = S_TX;
      S_TX:      if (last_rd) state_d = S_RX_WAIT;
      S_RX_WAIT: if (stat_edge || tmo_hit) state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_DONE;
`ifdef RS485_CTRL_RETRY_EN
        if (chk_err != 3'd0 && retry_q != 3'd0) state_d = S_GAP;
`endif
      end
`ifdef RS485_CTRL_RETRY_EN
      S_GAP:     if (gap_q == 16'(G_GAP - 1)) state_d = S_TX;
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.p_out_busy    = (state_q != S_IDLE);
    bus.p_out_done    = (state_q == S_DONE);
    bus.p_out_txd_rdy = (state_q == S_TX);
  end

  assign bus.p_out_txd      = txd_q;
  assign bus.p_out_err      = err_q;
  assign bus.p_out_ack_len  = ack_len_q;
  assign bus.p_out_ack_data = ack_data_q;

  always_comb begin
    adr_d = adr_q;  cmd_d = cmd_q;  len_d = len_q;  data_d = data_q;
    tx_idx_d = tx_idx_q;  txd_d = txd_q;  rx_idx_d = rx_idx_q;
    ack_len_d = ack_len_q;  ack_data_d = ack_data_q;  tmo_cnt_d = tmo_cnt_q;
    mism_d = mism_q;  ovf_d = ovf_q;  tmo_d = tmo_q;  rx_err_d = rx_err_q;  err_d = err_q;
`ifdef RS485_CTRL_RETRY_EN
    retry_d = retry_q;  gap_d = gap_q;
`endif
    case (state_q)
      S_IDLE: if (bus.p_in_req) begin
        adr_d  = bus.p_in_req_adr;
        cmd_d  = bus.p_in_req_cmd;
        len_d  = (bus.p_in_req_len > 3'd4) ? 3'd4 : bus.p_in_req_len;
        data_d = bus.p_in_req_data;
        tx_idx_d = 3'd0;  txd_d = bus.p_in_req_adr;
        rx_idx_d = 3'd0;  ack_len_d = 3'd0;  ack_data_d = 32'd0;
        mism_d = 1'b0;  ovf_d = 1'b0;  tmo_d = 1'b0;  rx_err_d = 1'b0;  err_d = 3'd0;
`ifdef RS485_CTRL_RETRY_EN
        retry_d = 3'(G_RETRY);
`endif
      end
      S_TX: if (bus.p_in_txd_rd) begin
        tx_idx_d  = tx_idx_q + 3'd1;
        txd_d     = tx_byte(tx_idx_q + 3'd1, adr_q, cmd_q, data_q);
        tmo_cnt_d = 24'd0;
      end
      S_RX_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 24'd1;
        // Byte capture precedes the edge check so S_CHECK sees this byte too
        if (bus.p_in_rxd_wr) begin
          if (rx_idx_q != 3'd6) rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q >= 3'd2 && rx_idx_q <= 3'd5) ack_len_d = ack_len_q + 3'd1;
          case (rx_idx_q)
            3'd0:    if (bus.p_in_rxd != adr_q) mism_d = 1'b1;
            3'd1:    if (bus.p_in_rxd != cmd_q) mism_d = 1'b1;
            3'd2:    ack_data_d[31:24] = bus.p_in_rxd;
            3'd3:    ack_data_d[23:16] = bus.p_in_rxd;
            3'd4:    ack_data_d[15:8]  = bus.p_in_rxd;
            3'd5:    ack_data_d[7:0]   = bus.p_in_rxd;
            default: ovf_d = 1'b1;
          endcase
        end
        if (stat_edge)    rx_err_d = (bus.p_in_status == 3'd2);
        else if (tmo_hit) tmo_d = 1'b1;
      end
      S_CHECK: begin
        err_d = chk_err;
`ifdef RS485_CTRL_RETRY_EN
        if (chk_err != 3'd0 && retry_q != 3'd0) begin
          retry_d  = retry_q - 3'd1;
          rx_idx_d = 3'd0;  ack_len_d = 3'd0;  ack_data_d = 32'd0;
          mism_d = 1'b0;  ovf_d = 1'b0;  tmo_d = 1'b0;  rx_err_d = 1'b0;
          gap_d  = 16'd0;
        end
`endif
      end
`ifdef RS485_CTRL_RETRY_EN
      S_GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == 16'(G_GAP - 1)) begin
          tx_idx_d = 3'd0;
          txd_d    = adr_q;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) begin
      adr_q <= 8'd0;  cmd_q <= 8'd0;  len_q <= 3'd0;  data_q <= 32'd0;
      tx_idx_q <= 3'd0;  txd_q <= 8'd0;  rx_idx_q <= 3'd0;
      ack_len_q <= 3'd0;  ack_data_q <= 32'd0;  tmo_cnt_q <= 24'd0;
      mism_q <= 1'b0;  ovf_q <= 1'b0;  tmo_q <= 1'b0;  rx_err_q <= 1'b0;
      err_q <= 3'd0;  stat_prev_q <= 1'b0;
`ifdef RS485_CTRL_RETRY_EN
      retry_q <= 3'd0;  gap_q <= 16'd0;
`endif
    end else begin
      adr_q <= adr_d;  cmd_q <= cmd_d;  len_q <= len_d;  data_q <= data_d;
      tx_idx_q <= tx_idx_d;  txd_q <= txd_d;  rx_idx_q <= rx_idx_d;
      ack_len_q <= ack_len_d;  ack_data_q <= ack_data_d;  tmo_cnt_q <= tmo_cnt_d;
      mism_q <= mism_d;  ovf_q <= ovf_d;  tmo_q <= tmo_d;  rx_err_q <= rx_err_d;
      err_q <= err_d;  stat_prev_q <= (bus.p_in_status != 3'd0);
`ifdef RS485_CTRL_RETRY_EN
      retry_q <= retry_d;  gap_q <= gap_d;
`endif
    end
  end
endmodule

// File: tb/tb_rs485_txn_ctrl.sv
// tb/tb_rs485_txn_ctrl.sv - directed bench for rs485_txn_ctrl with a master485n byte model
`timescale 1ns/1ps
module tb_rs485_txn_ctrl;
  localparam int TMO = 1000, RETRY = 2, GAP = 16;
`ifdef RS485_CTRL_RETRY_EN
  localparam int ATT = RETRY + 1;
`else
  localparam int ATT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vec = 0;
  int   miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs485_txn_ctrl_if bus();
  rs485_txn_ctrl #(.G_TIMEOUT(TMO), .G_RETRY(RETRY), .G_GAP(GAP)) dut (
    .p_in_clk(clk), .p_in_rst(rst), .bus(bus)
  );

  // PHY model configuration and logs
  bit         phy_en = 1'b1;
  logic [7:0] rsp_b [8];
  int         rsp_n;
  logic [2:0] rsp_st [4];
  bit         rsp_silent [4];
  logic [7:0] tx_log [$];
  int         fr_len [$];
  int         fr_start [$];

  // Results of the last transaction
  bit          got_ok;
  int          done_cyc;
  logic [2:0]  got_err, got_len;
  logic [31:0] got_data;
  logic        got_done_nx, got_busy_nx;

  initial begin
    bus.p_in_txd_rd = 1'b0;
    bus.p_in_rxd_wr = 1'b0;
    bus.p_in_rxd    = 8'd0;
    bus.p_in_status = 3'd0;
    forever begin
      @(negedge clk);
      if (phy_en && !rst && bus.p_out_txd_rdy) begin
        int nb, att;
        bus.p_in_status = 3'd0;
        fr_start.push_back(cyc);
        nb = 0;
        do begin
          repeat (2) @(negedge clk);
          tx_log.push_back(bus.p_out_txd);
          bus.p_in_txd_rd = 1'b1;
          @(negedge clk);
          bus.p_in_txd_rd = 1'b0;
          nb++;
        end while (bus.p_out_txd_rdy && nb < 8);
        fr_len.push_back(nb);
        att = fr_len.size() - 1;
        if (att > 3) att = 3;
        repeat (3) @(negedge clk);
        if (!rsp_silent[att]) begin
          for (int i = 0; i < rsp_n; i++) begin
            bus.p_in_rxd    = rsp_b[i];
            bus.p_in_rxd_wr = 1'b1;
            @(negedge clk);
            bus.p_in_rxd_wr = 1'b0;
            @(negedge clk);
          end
          bus.p_in_status = rsp_st[att];
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, limit 2ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_rsp(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, input int n);
    rsp_b[0] = b0; rsp_b[1] = b1; rsp_b[2] = b2; rsp_b[3] = b3;
    rsp_b[4] = b4; rsp_b[5] = b5; rsp_b[6] = b6; rsp_b[7] = 8'h00;
    rsp_n = n;
    for (int i = 0; i < 4; i++) begin
      rsp_st[i] = 3'd1;
      rsp_silent[i] = 1'b0;
    end
  endtask

  task automatic send_req(input logic [7:0] adr, cmd, input logic [2:0] len,
                          input logic [31:0] data);
    @(negedge clk);
    bus.p_in_req_adr  = adr;
    bus.p_in_req_cmd  = cmd;
    bus.p_in_req_len  = len;
    bus.p_in_req_data = data;
    bus.p_in_req      = 1'b1;
    @(negedge clk);
    bus.p_in_req      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    got_ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.p_out_done) begin
        got_ok = 1'b1;
        break;
      end
    end
    done_cyc = cyc;
    got_err  = bus.p_out_err;
    got_len  = bus.p_out_ack_len;
    got_data = bus.p_out_ack_data;
    @(negedge clk);
    got_done_nx = bus.p_out_done;
    got_busy_nx = bus.p_out_busy;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] adr, cmd, input logic [2:0] len,
                         input logic [31:0] data, input int budget);
    tx_log.delete(); fr_len.delete(); fr_start.delete();
    send_req(adr, cmd, len, data);
    wait_done(budget);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    @(negedge clk);
    vec++; if (bus.p_out_busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b want 0", bus.p_out_busy); end
    vec++; if (bus.p_out_done !== 1'b0) begin miss++; $display("FAIL rst_done: got %b want 0", bus.p_out_done); end
    vec++; if (bus.p_out_txd_rdy !== 1'b0) begin miss++; $display("FAIL rst_txd_rdy: got %b want 0", bus.p_out_txd_rdy); end
    vec++; if (bus.p_out_txd !== 8'h00) begin miss++; $display("FAIL rst_txd: got %h want 00", bus.p_out_txd); end
    vec++; if (bus.p_out_err !== 3'd0) begin miss++; $display("FAIL rst_err: got %0d want 0", bus.p_out_err); end
    vec++; if (bus.p_out_ack_len !== 3'd0) begin miss++; $display("FAIL rst_ack_len: got %0d want 0", bus.p_out_ack_len); end
    vec++; if (bus.p_out_ack_data !== 32'h0) begin miss++; $display("FAIL rst_ack_data: got %h want 0", bus.p_out_ack_data); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] exp_q [$];
    exp_q = '{8'h05, 8'h11, 8'hA1, 8'hB2};
    set_rsp(8'h05, 8'h11, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 4);
    tx_log.delete(); fr_len.delete(); fr_start.delete();
    send_req(8'h05, 8'h11, 3'd2, 32'hA1B2_3344);
    vec++; if (bus.p_out_busy !== 1'b1) begin miss++; $display("FAIL basic_busy_rise: got %b want 1", bus.p_out_busy); end
    vec++; if (bus.p_out_txd_rdy !== 1'b1) begin miss++; $display("FAIL basic_rdy_rise: got %b want 1", bus.p_out_txd_rdy); end
    bus.p_in_req_adr = 8'h77;
    bus.p_in_req = 1'b1;
    @(negedge clk);
    bus.p_in_req = 1'b0;
    wait_done(500);
    vec++; if (got_ok !== 1'b1) begin miss++; $display("FAIL basic_done: got %b want 1", got_ok); end
    vec++; if (fr_len.size() != 1) begin miss++; $display("FAIL basic_frames: got %0d want 1", fr_len.size()); end
    vec++; if (tx_log.size() != 4) begin miss++; $display("FAIL basic_txd_count: got %0d want 4", tx_log.size()); end
    for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
      vec++; if (tx_log[i] !== exp_q[i]) begin miss++; $display("FAIL basic_txd[%0d]: got %h want %h", i, tx_log[i], exp_q[i]); end
    end
    vec++; if (got_err !== 3'd0) begin miss++; $display("FAIL basic_err: got %0d want 0", got_err); end
    vec++; if (got_len !== 3'd2) begin miss++; $display("FAIL basic_ack_len: got %0d want 2", got_len); end
    vec++; if (got_data !== 32'hC3D4_0000) begin miss++; $display("FAIL basic_ack_data: got %h want c3d40000", got_data); end
    vec++; if (got_done_nx !== 1'b0) begin miss++; $display("FAIL basic_done_width: got %b want 0", got_done_nx); end
    vec++; if (got_busy_nx !== 1'b0) begin miss++; $display("FAIL basic_busy_fall: got %b want 0", got_busy_nx); end
    vec++; if (bus.p_out_busy !== 1'b0) begin miss++; $display("FAIL basic_req_not_queued: got busy %b want 0", bus.p_out_busy); end
    vec++; if (bus.p_out_ack_data !== 32'hC3D4_0000) begin miss++; $display("FAIL basic_ack_hold: got %h want c3d40000", bus.p_out_ack_data); end
  endtask

  task automatic test_len_clamp;
    logic [7:0] exp_q [$];
    exp_q = '{8'h3C, 8'h22, 8'h01, 8'h02, 8'h03, 8'h04};
    set_rsp(8'h3C, 8'h22, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 6);
    run_txn(8'h3C, 8'h22, 3'd7, 32'h0102_0304, 500);
    vec++; if (tx_log.size() != 6) begin miss++; $display("FAIL clamp_txd_count: got %0d want 6", tx_log.size()); end
    for (int i = 0; i < 6 && i < tx_log.size(); i++) begin
      vec++; if (tx_log[i] !== exp_q[i]) begin miss++; $display("FAIL clamp_txd[%0d]: got %h want %h", i, tx_log[i], exp_q[i]); end
    end
    vec++; if (got_err !== 3'd0) begin miss++; $display("FAIL clamp_err: got %0d want 0", got_err); end
    vec++; if (got_len !== 3'd4) begin miss++; $display("FAIL clamp_ack_len: got %0d want 4", got_len); end
    vec++; if (got_data !== 32'hAABB_CCDD) begin miss++; $display("FAIL clamp_ack_data: got %h want aabbccdd", got_data); end
  endtask

  task automatic test_timeout_retry;
    set_rsp(8'h05, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    for (int i = 0; i < 4; i++) rsp_silent[i] = 1'b1;
    run_txn(8'h05, 8'h11, 3'd0, 32'h0, 6000);
    vec++; if (got_ok !== 1'b1) begin miss++; $display("FAIL tmo_done: got %b want 1", got_ok); end
    vec++; if (fr_len.size() != ATT) begin miss++; $display("FAIL tmo_frames: got %0d want %0d", fr_len.size(), ATT); end
    vec++; if (tx_log.size() != 2 * ATT) begin miss++; $display("FAIL tmo_txd_count: got %0d want %0d", tx_log.size(), 2 * ATT); end
    for (int i = 0; i < tx_log.size() && i < 2 * ATT; i++) begin
      vec++; if (tx_log[i] !== ((i % 2 == 0) ? 8'h05 : 8'h11)) begin miss++; $display("FAIL tmo_txd[%0d]: got %h want %h", i, tx_log[i], (i % 2 == 0) ? 8'h05 : 8'h11); end
    end
    vec++; if (got_err !== 3'd1) begin miss++; $display("FAIL tmo_err: got %0d want 1", got_err); end
    vec++; if (got_len !== 3'd0) begin miss++; $display("FAIL tmo_ack_len: got %0d want 0", got_len); end
    vec++; if (fr_start.size() == 0 || done_cyc - fr_start[0] < ATT * TMO) begin miss++; $display("FAIL tmo_duration: got %0d cycles want >= %0d", (fr_start.size() == 0) ? 0 : done_cyc - fr_start[0], ATT * TMO); end
    for (int k = 0; k + 1 < fr_start.size(); k++) begin
      vec++; if (fr_start[k + 1] - fr_start[k] < TMO + GAP) begin miss++; $display("FAIL tmo_spacing[%0d]: got %0d want >= %0d", k, fr_start[k + 1] - fr_start[k], TMO + GAP); end
    end
  endtask

  task automatic test_rx_err_retry;
    set_rsp(8'h07, 8'h30, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    rsp_st[0] = 3'd2;
    run_txn(8'h07, 8'h30, 3'd1, 32'h5A00_0000, 1000);
    vec++; if (got_ok !== 1'b1) begin miss++; $display("FAIL rxerr_done: got %b want 1", got_ok); end
    vec++; if (fr_len.size() != ((ATT > 1) ? 2 : 1)) begin miss++; $display("FAIL rxerr_frames: got %0d want %0d", fr_len.size(), (ATT > 1) ? 2 : 1); end
    vec++; if (got_err !== ((ATT > 1) ? 3'd0 : 3'd2)) begin miss++; $display("FAIL rxerr_err: got %0d want %0d", got_err, (ATT > 1) ? 0 : 2); end
    vec++; if (got_len !== 3'd1) begin miss++; $display("FAIL rxerr_ack_len: got %0d want 1", got_len); end
    vec++; if (got_data !== 32'h9900_0000) begin miss++; $display("FAIL rxerr_ack_data: got %h want 99000000", got_data); end
  endtask

  task automatic test_mismatch;
    set_rsp(8'h06, 8'h11, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 4);
    run_txn(8'h05, 8'h11, 3'd2, 32'hA1B2_0000, 1500);
    vec++; if (fr_len.size() != ATT) begin miss++; $display("FAIL mism_frames: got %0d want %0d", fr_len.size(), ATT); end
    vec++; if (got_err !== 3'd3) begin miss++; $display("FAIL mism_err: got %0d want 3", got_err); end
    vec++; if (got_len !== 3'd2) begin miss++; $display("FAIL mism_ack_len: got %0d want 2", got_len); end
    vec++; if (got_data !== 32'hC3D4_0000) begin miss++; $display("FAIL mism_ack_data: got %h want c3d40000", got_data); end
  endtask

  task automatic test_overflow;
    set_rsp(8'h05, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 7);
    run_txn(8'h05, 8'h11, 3'd0, 32'h0, 1500);
    vec++; if (fr_len.size() != ATT) begin miss++; $display("FAIL ovf_frames: got %0d want %0d", fr_len.size(), ATT); end
    vec++; if (got_err !== 3'd4) begin miss++; $display("FAIL ovf_err: got %0d want 4", got_err); end
    vec++; if (got_len !== 3'd4) begin miss++; $display("FAIL ovf_ack_len: got %0d want 4", got_len); end
    vec++; if (got_data !== 32'h1122_3344) begin miss++; $display("FAIL ovf_ack_data: got %h want 11223344", got_data); end
  endtask

  task automatic test_short_frame;
    set_rsp(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    run_txn(8'h05, 8'h11, 3'd0, 32'h0, 1500);
    vec++; if (got_err !== 3'd4) begin miss++; $display("FAIL short_err: got %0d want 4", got_err); end
    vec++; if (got_len !== 3'd0) begin miss++; $display("FAIL short_ack_len: got %0d want 0", got_len); end
  endtask

  task automatic test_reset_mid_tx;
    int done_seen;
    phy_en = 1'b0;
    send_req(8'h05, 8'h11, 3'd2, 32'hA1B2_3344);
    repeat (2) begin
      bus.p_in_txd_rd = 1'b1;
      @(negedge clk);
      bus.p_in_txd_rd = 1'b0;
      @(negedge clk);
    end
    vec++; if (bus.p_out_txd !== 8'hA1) begin miss++; $display("FAIL rmid_txd_byte2: got %h want a1", bus.p_out_txd); end
    #2 rst = 1'b1;
    #1;
    vec++; if (bus.p_out_txd_rdy !== 1'b0) begin miss++; $display("FAIL rmid_rdy_async: got %b want 0", bus.p_out_txd_rdy); end
    vec++; if (bus.p_out_busy !== 1'b0) begin miss++; $display("FAIL rmid_busy_async: got %b want 0", bus.p_out_busy); end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.p_out_done) done_seen++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.p_out_done) done_seen++;
    end
    vec++; if (done_seen != 0) begin miss++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_seen); end
    phy_en = 1'b1;
    set_rsp(8'h05, 8'h11, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 4);
    run_txn(8'h05, 8'h11, 3'd2, 32'hA1B2_3344, 500);
    vec++; if (got_ok !== 1'b1) begin miss++; $display("FAIL rmid_rerun_done: got %b want 1", got_ok); end
    vec++; if (tx_log.size() != 4) begin miss++; $display("FAIL rmid_rerun_txd_count: got %0d want 4", tx_log.size()); end
    vec++; if (got_err !== 3'd0) begin miss++; $display("FAIL rmid_rerun_err: got %0d want 0", got_err); end
    vec++; if (got_data !== 32'hC3D4_0000) begin miss++; $display("FAIL rmid_rerun_ack_data: got %h want c3d40000", got_data); end
  endtask

  initial begin
    bus.p_in_req      = 1'b0;
    bus.p_in_req_adr  = 8'h00;
    bus.p_in_req_cmd  = 8'h00;
    bus.p_in_req_len  = 3'd0;
    bus.p_in_req_data = 32'h0;
    set_rsp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    test_reset();
    test_basic();
    test_len_clamp();
    test_timeout_retry();
    test_rx_err_retry();
    test_mismatch();
    test_overflow();
    test_short_frame();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
